// File: rtl/kfmmc_host_pkg.sv
// Shared definitions for the MMC host bridge: CPU register map, status bit
// positions and the receive-acknowledge state type.
package kfmmc_host_pkg;

  // CPU register addresses (3-bit window)
  localparam logic [2:0] REG_DATA       = 3'd0;  // wr: tx data strobe, rd: FIFO head
  localparam logic [2:0] REG_COMMAND    = 3'd1;  // wr: command strobe
  localparam logic [2:0] REG_STATUS     = 3'd1;  // rd: drive/FIFO status
  localparam logic [2:0] REG_BLK_ADDR_1 = 3'd2;
  localparam logic [2:0] REG_BLK_ADDR_2 = 3'd3;
  localparam logic [2:0] REG_BLK_ADDR_3 = 3'd4;
  localparam logic [2:0] REG_BLK_ADDR_4 = 3'd5;
  localparam logic [2:0] REG_IRQ        = 3'd6;  // wr: enable, rd: {enable, flags}
  localparam logic [2:0] REG_COUNT      = 3'd7;  // wr: flush, rd: FIFO count

  // Interrupt flag bit positions
  localparam int STK_FIFO    = 0;  // live: FIFO not empty
  localparam int STK_RD_DONE = 1;  // sticky: read completion
  localparam int STK_WR_REQ  = 2;  // live: drive requests write data
  localparam int STK_WR_DONE = 3;  // sticky: write completion

  typedef enum logic [1:0] {ACK_IDLE, ACK_STROBE, ACK_HOLD} ack_state_t;

endpackage

// File: rtl/kfmmc_byte_fifo.sv
// Small byte FIFO holding bytes drained from the drive until the CPU reads
// them.
//   clock, reset_n : clock, async active-low reset
//   push, din      : write a byte (ignored when full unless a pop coincides)
//   pop            : drop the head byte (ignored when empty)
//   flush          : empty the FIFO; wins over a coincident push/pop
//   head           : current head byte (undefined when empty)
//   empty, full    : occupancy flags
//   count          : number of stored bytes
module kfmmc_byte_fifo #(
  parameter int fifo_depth = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               push,
  input  logic [7:0]                         din,
  input  logic                               pop,
  input  logic                               flush,
  output logic [7:0]                         head,
  output logic                               empty,
  output logic                               full,
  output logic [$clog2(fifo_depth+1)-1:0]    count
);
  localparam int CW = $clog2(fifo_depth + 1);
  localparam int PW = $clog2(fifo_depth);

  logic [7:0]    mem [fifo_depth];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(fifo_depth));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/kfmmc_host_bridge.sv
// CPU-side bridge in front of the MMC drive block.
//   clock, reset_n           : clock, async active-low reset
//   cpu_chip_select/address/write/read/data_in/data_out : 8-bit CPU window
//   interrupt                : registered CPU interrupt request
//   data_bus + write_*       : drive write strobes with the last written byte
//   read_data                : one-cycle acknowledge for a received byte
//   read_data_byte           : received byte from the drive
//   drive_busy, *_interface_error : drive status, shown in the status register
//   *_interrupt              : transient drive events
module kfmmc_host_bridge
  import kfmmc_host_pkg::*;
#(
  parameter int fifo_depth = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cpu_chip_select,
  input  logic [2:0] cpu_address,
  input  logic       cpu_write,
  input  logic       cpu_read,
  input  logic [7:0] cpu_data_in,
  output logic [7:0] cpu_data_out,
  output logic       interrupt,
  output logic [7:0] data_bus,
  output logic       write_block_address_1,
  output logic       write_block_address_2,
  output logic       write_block_address_3,
  output logic       write_block_address_4,
  output logic       write_command,
  output logic       write_data,
  output logic       read_data,
  input  logic [7:0] read_data_byte,
  input  logic       drive_busy,
  input  logic       read_interface_error,
  input  logic       write_interface_error,
  input  logic       read_byte_interrupt,
  input  logic       read_completion_interrupt,
  input  logic       request_write_data_interrupt,
  input  logic       write_completion_interrupt
);
  localparam int CW = $clog2(fifo_depth + 1);

  logic          wr_access;
  logic          rd_access;
  logic          wr_prev_p0;
  logic          rd_prev_p0;
  logic [2:0]    rd_addr_p0;
  logic          rd_vld_p1;
  logic [2:0]    rd_addr_p1;
  logic          wr_start;
  logic          rd_end;
  logic [3:0]    irq_en;
  logic          rd_done_flag;
  logic          wr_done_flag;
  logic [3:0]    sticky;
  logic          sticky_clr;
  ack_state_t    ack_state;
  logic          byte_accept;
  logic          fifo_pop;
  logic          fifo_flush;
  logic [7:0]    fifo_head;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;

  assign wr_access  = cpu_chip_select & cpu_write;
  assign rd_access  = cpu_chip_select & cpu_read;
  assign wr_start   = wr_access & ~wr_prev_p0;
  assign rd_end     = rd_prev_p0 & ~rd_access;
  assign fifo_flush = wr_start && (cpu_address == REG_COUNT);
  assign fifo_pop   = rd_vld_p1 && (rd_addr_p1 == REG_DATA);
  assign sticky_clr = rd_vld_p1 && (rd_addr_p1 == REG_IRQ);
  assign byte_accept = (ack_state == ACK_IDLE) && read_byte_interrupt &&
                       (!fifo_full || fifo_pop);

  always_comb begin
    sticky              = '0;
    sticky[STK_FIFO]    = ~fifo_empty;
    sticky[STK_RD_DONE] = rd_done_flag;
    sticky[STK_WR_REQ]  = request_write_data_interrupt;
    sticky[STK_WR_DONE] = wr_done_flag;
  end

  // ---- p0: write edge detect -> registered one-cycle strobes ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev_p0            <= 1'b0;
      write_data            <= 1'b0;
      write_command         <= 1'b0;
      write_block_address_1 <= 1'b0;
      write_block_address_2 <= 1'b0;
      write_block_address_3 <= 1'b0;
      write_block_address_4 <= 1'b0;
      data_bus              <= 8'h00;
      irq_en                <= 4'h0;
    end else begin
      wr_prev_p0            <= wr_access;
      write_data            <= wr_start && (cpu_address == REG_DATA);
      write_command         <= wr_start && (cpu_address == REG_COMMAND);
      write_block_address_1 <= wr_start && (cpu_address == REG_BLK_ADDR_1);
      write_block_address_2 <= wr_start && (cpu_address == REG_BLK_ADDR_2);
      write_block_address_3 <= wr_start && (cpu_address == REG_BLK_ADDR_3);
      write_block_address_4 <= wr_start && (cpu_address == REG_BLK_ADDR_4);
      if (wr_start) begin
        data_bus <= cpu_data_in;
        if (cpu_address == REG_IRQ) irq_en <= cpu_data_in[3:0];
      end
    end
  end

  // ---- p0/p1: read falling edge detected, side effect applied a clock later ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_prev_p0 <= 1'b0;
      rd_vld_p1  <= 1'b0;
    end else begin
      rd_prev_p0 <= rd_access;
      rd_vld_p1  <= rd_end;
    end
  end

  // The address is held from the access itself; it may be invalid at the falling edge.
  always_ff @(posedge clock) begin
    if (rd_access) rd_addr_p0 <= cpu_address;
    rd_addr_p1 <= rd_addr_p0;
  end

  // ---- interrupt flags and registered request ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_done_flag <= 1'b0;
      wr_done_flag <= 1'b0;
      interrupt    <= 1'b0;
    end else begin
      // Set wins over a coincident clear.
      rd_done_flag <= read_completion_interrupt  | (rd_done_flag & ~sticky_clr);
      wr_done_flag <= write_completion_interrupt | (wr_done_flag & ~sticky_clr);
      interrupt    <= |(irq_en & sticky);
    end
  end

  // ---- receive acknowledge: accept, strobe, then one blind cycle ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_state <= ACK_IDLE;
      read_data <= 1'b0;
    end else begin
      case (ack_state)
        ACK_IDLE: begin
          read_data <= byte_accept;
          if (byte_accept) ack_state <= ACK_STROBE;
        end
        ACK_STROBE: begin
          read_data <= 1'b0;
          ack_state <= ACK_HOLD;
        end
        // Drive is still clearing its flag after seeing read_data; ignore it.
        ACK_HOLD: begin
          read_data <= 1'b0;
          ack_state <= ACK_IDLE;
        end
        default: begin
          read_data <= 1'b0;
          ack_state <= ACK_IDLE;
        end
      endcase
    end
  end

  kfmmc_byte_fifo #(.fifo_depth(fifo_depth)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (byte_accept),
    .din     (read_data_byte),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  always_comb begin
    cpu_data_out = 8'h00;
    if (rd_access) begin
      case (cpu_address)
        REG_DATA:   cpu_data_out = fifo_empty ? 8'h00 : fifo_head;
        REG_STATUS: cpu_data_out = {drive_busy, read_interface_error, write_interface_error,
                                    1'b0, fifo_full, ~fifo_empty, 2'b00};
        REG_IRQ:    cpu_data_out = {irq_en, sticky};
        REG_COUNT:  cpu_data_out = 8'(fifo_count);
        default:    cpu_data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_kfmmc_host_bridge.sv
// Self-checking bench for kfmmc_host_bridge: a register-map level model
// (captured-byte log with a read index, flag bits, enable) predicts every read.
module tb_kfmmc_host_bridge;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_chip_select, cpu_write, cpu_read;
  logic [2:0] cpu_address;
  logic [7:0] cpu_data_in, cpu_data_out, data_bus, read_data_byte;
  logic       interrupt, write_block_address_1, write_block_address_2;
  logic       write_block_address_3, write_block_address_4, write_command, write_data;
  logic       read_data, drive_busy, read_interface_error, write_interface_error;
  logic       read_byte_interrupt, read_completion_interrupt;
  logic       request_write_data_interrupt, write_completion_interrupt;

  kfmmc_host_bridge #(.fifo_depth(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .cpu_chip_select(cpu_chip_select),
    .cpu_address(cpu_address), .cpu_write(cpu_write), .cpu_read(cpu_read),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .interrupt(interrupt),
    .data_bus(data_bus), .write_block_address_1(write_block_address_1),
    .write_block_address_2(write_block_address_2),
    .write_block_address_3(write_block_address_3),
    .write_block_address_4(write_block_address_4), .write_command(write_command),
    .write_data(write_data), .read_data(read_data), .read_data_byte(read_data_byte),
    .drive_busy(drive_busy), .read_interface_error(read_interface_error),
    .write_interface_error(write_interface_error),
    .read_byte_interrupt(read_byte_interrupt),
    .read_completion_interrupt(read_completion_interrupt),
    .request_write_data_interrupt(request_write_data_interrupt),
    .write_completion_interrupt(write_completion_interrupt)
  );

  initial forever #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Drive-side model state (written only by the drive/monitor process)
  int         cyc = 0;
  int         ack_cnt = 0;
  int         ack_stamp[$];
  logic [7:0] cap_log[$];   // every byte the bridge acknowledged, in order
  int         src_idx = 0;
  int         strb_cnt[6];
  logic [7:0] strb_bus[6];

  // Main-process state
  logic [7:0] src[256];     // bytes offered by the drive
  int         src_n = 0;
  int         rd_idx = 0;   // model FIFO = cap_log[rd_idx .. $]
  logic [3:0] en_m = 4'h0;
  logic       rc_m = 1'b0;
  logic       wc_m = 1'b0;
  int         base[6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic int msize();
    return cap_log.size() - rd_idx;
  endfunction

  function automatic logic [7:0] exp_reg(input logic [2:0] a);
    int n;
    logic [7:0] r;
    n = msize();
    case (a)
      3'd0:    r = (n > 0) ? cap_log[rd_idx] : 8'h00;
      3'd1:    r = {drive_busy, read_interface_error, write_interface_error, 1'b0,
                    n == DEPTH, n != 0, 2'b00};
      3'd6:    r = {en_m, wc_m, request_write_data_interrupt, rc_m, n != 0};
      3'd7:    r = 8'(n);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic exp_irq();
    return |(en_m & {wc_m, request_write_data_interrupt, rc_m, msize() != 0});
  endfunction

  // Drive model + strobe monitor: present bytes one at a time, drop the flag on read_data.
  initial begin
    read_byte_interrupt = 1'b0;
    read_data_byte = 8'h00;
    for (int i = 0; i < 6; i++) begin strb_cnt[i] = 0; strb_bus[i] = 8'h00; end
    forever begin
      logic [5:0] sv;
      @(negedge clock);
      cyc++;
      sv = {write_block_address_4, write_block_address_3, write_block_address_2,
            write_block_address_1, write_command, write_data};
      for (int i = 0; i < 6; i++)
        if (sv[i]) begin strb_cnt[i]++; strb_bus[i] = data_bus; end
      if (read_byte_interrupt && read_data) begin
        ack_cnt++;
        ack_stamp.push_back(cyc);
        cap_log.push_back(read_data_byte);
        read_byte_interrupt = 1'b0;
      end
      if (!read_byte_interrupt && src_idx < src_n) begin
        read_data_byte = src[src_idx];
        src_idx++;
        read_byte_interrupt = 1'b1;
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input int hold);
    @(negedge clock);
    cpu_chip_select = 1'b1; cpu_write = 1'b1; cpu_address = a; cpu_data_in = d;
    repeat (hold) @(negedge clock);
    cpu_chip_select = 1'b0; cpu_write = 1'b0;
    @(negedge clock);
    if (a == 3'd6) en_m = d[3:0];
    if (a == 3'd7) rd_idx = cap_log.size();
  endtask

  task automatic rd(input logic [2:0] a, input string tag, output logic [7:0] d);
    @(negedge clock);
    cpu_chip_select = 1'b1; cpu_read = 1'b1; cpu_address = a;
    #1;
    d = cpu_data_out;
    chk(tag, d, exp_reg(a));
    if (a == 3'd0 && msize() > 0) rd_idx++;
    if (a == 3'd6) begin rc_m = 1'b0; wc_m = 1'b0; end
    @(negedge clock);
    cpu_chip_select = 1'b0; cpu_read = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic pulse(input bit wc);
    @(negedge clock);
    if (wc) write_completion_interrupt = 1'b1; else read_completion_interrupt = 1'b1;
    @(negedge clock);
    write_completion_interrupt = 1'b0; read_completion_interrupt = 1'b0;
    if (wc) wc_m = 1'b1; else rc_m = 1'b1;
  endtask

  task automatic offer(input logic [7:0] b);
    if (src_n < 256) begin src[src_n] = b; src_n++; end
  endtask

  task automatic snap();
    for (int i = 0; i < 6; i++) base[i] = strb_cnt[i];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    int a0, s0, viol, k;
    cpu_chip_select = 0; cpu_write = 0; cpu_read = 0; cpu_address = 0; cpu_data_in = 0;
    drive_busy = 0; read_interface_error = 0; write_interface_error = 0;
    read_completion_interrupt = 0; request_write_data_interrupt = 0;
    write_completion_interrupt = 0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_strobes", {write_data, write_command, write_block_address_1,
        write_block_address_2, write_block_address_3, write_block_address_4}, 0);
    chk("rst_bus", data_bus, 8'h00);
    chk("rst_ack", read_data, 0);
    chk("rst_irq", interrupt, 0);
    reset_n = 1'b1;
    rd(3'd7, "rst_count", d);
    rd(3'd1, "rst_status", d);
    rd(3'd6, "rst_irqreg", d);

    // Write strobes, one pulse each, long cpu_write still one pulse
    snap();
    wr(3'd2, 8'h12, 1); wr(3'd3, 8'h34, 1); wr(3'd4, 8'h56, 1); wr(3'd5, 8'h78, 1);
    wr(3'd1, 8'h51, 5);
    chk("wd_none", strb_cnt[0] - base[0], 0);
    chk("cmd_cnt", strb_cnt[1] - base[1], 1);
    chk("cmd_bus", strb_bus[1], 8'h51);
    chk("blk1_cnt", strb_cnt[2] - base[2], 1);
    chk("blk1_bus", strb_bus[2], 8'h12);
    chk("blk2_cnt", strb_cnt[3] - base[3], 1);
    chk("blk2_bus", strb_bus[3], 8'h34);
    chk("blk3_cnt", strb_cnt[4] - base[4], 1);
    chk("blk3_bus", strb_bus[4], 8'h56);
    chk("blk4_cnt", strb_cnt[5] - base[5], 1);
    chk("blk4_bus", strb_bus[5], 8'h78);
    wr(3'd0, 8'h9C, 2);
    chk("wd_cnt", strb_cnt[0] - base[0], 1);
    repeat (3) @(negedge clock);
    chk("bus_hold", data_bus, 8'h9C);

    // Six bytes, no reads: four acks then stall
    a0 = ack_cnt;
    for (int i = 0; i < 6; i++) offer(8'hA0 + 8'(i));
    repeat (30) @(negedge clock);
    chk("stall_acks", ack_cnt - a0, 4);
    rd(3'd1, "full_status", d);
    chk("full_status_val", d, 8'h0C);
    rd(3'd7, "full_count", d);
    chk("full_count_val", d, 8'h04);
    rd(3'd0, "head_a0", d);
    chk("head_a0_val", d, 8'hA0);
    k = 0;
    while (ack_cnt - a0 < 5 && k < 3) begin @(negedge clock); k++; end
    chk("fifth_ack", ack_cnt - a0, 5);
    for (int i = 0; i < 5; i++) rd(3'd0, "drain", d);
    chk("last_val", d, 8'hA5);
    rd(3'd0, "empty_head", d);
    chk("empty_head_val", d, 8'h00);
    rd(3'd7, "empty_count", d);
    chk("empty_count_val", d, 8'h00);

    // Back-to-back bytes: acks exactly 3 cycles apart, then flush
    s0 = ack_stamp.size();
    offer(8'h31); offer(8'h32); offer(8'h33);
    repeat (15) @(negedge clock);
    chk("b2b_n", ack_stamp.size() - s0, 3);
    if (ack_stamp.size() - s0 == 3) begin
      chk("b2b_gap1", ack_stamp[s0+1] - ack_stamp[s0], 3);
      chk("b2b_gap2", ack_stamp[s0+2] - ack_stamp[s0+1], 3);
    end
    rd(3'd7, "b2b_count", d);
    wr(3'd7, 8'h5A, 1);
    rd(3'd7, "flush_count", d);
    rd(3'd0, "flush_head", d);

    // Read-completion interrupt: sticky, registered, cleared by status read
    wr(3'd6, 8'h02, 1);
    pulse(1'b0);
    chk("irq_lat", interrupt, 0);
    @(negedge clock);
    chk("irq_rise", interrupt, 1);
    repeat (3) @(negedge clock);
    chk("irq_hold", interrupt, 1);
    rd(3'd6, "irqreg", d);
    chk("irqreg_val", d, 8'h22);
    @(negedge clock);
    chk("irq_fall", interrupt, 0);

    // Reset during ACK: async clear, pending byte re-served once
    wr(3'd6, 8'h00, 1);
    offer(8'hC3);
    k = 0;
    while (!read_data && k < 10) begin @(posedge clock); #1; k++; end
    chk("ack_seen", read_data, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_ack", read_data, 0);
    cpu_chip_select = 1'b1; cpu_read = 1'b1; cpu_address = 3'd7;
    #1;
    chk("rst_async_count", cpu_data_out, 8'h00);
    cpu_chip_select = 1'b0; cpu_read = 1'b0;
    rd_idx = cap_log.size(); en_m = 4'h0; rc_m = 1'b0; wc_m = 1'b0;
    a0 = ack_cnt;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("reserve_once", ack_cnt - a0, 1);
    rd(3'd7, "reserve_count", d);
    rd(3'd0, "reserve_head", d);
    chk("reserve_head_val", d, 8'hC3);

    // Randomized mix of drive traffic, CPU accesses and events
    for (int it = 0; it < 150; it++) begin
      logic [2:0] a;
      case ($urandom_range(0, 7))
        0: for (int j = $urandom_range(1, 3); j > 0; j--) offer(8'($urandom));
        1: rd(3'd0, "r_head", d);
        2: rd(3'd1, "r_status", d);
        3: rd(3'd7, "r_count", d);
        4: rd(3'd6, "r_irqreg", d);
        5: pulse(1'($urandom_range(0, 1)));
        6: begin
          @(negedge clock);
          drive_busy = 1'($urandom); read_interface_error = 1'($urandom);
          write_interface_error = 1'($urandom);
          request_write_data_interrupt = 1'($urandom);
          wr(3'd6, 8'($urandom) & 8'h0E, 1);
        end
        default: begin
          a = 3'($urandom_range(0, 5));
          d = 8'($urandom);
          snap();
          wr(a, d, $urandom_range(1, 3));
          chk("r_strb_cnt", strb_cnt[a] - base[a], 1);
          chk("r_strb_bus", strb_bus[a], d);
        end
      endcase
      @(negedge clock);
      chk("r_irq", interrupt, exp_irq());
    end

    repeat (20) @(negedge clock);
    rd(3'd7, "end_count", d);
    viol = 0;
    for (int i = 1; i < ack_stamp.size(); i++)
      if (ack_stamp[i] - ack_stamp[i-1] < 3) viol++;
    chk("ack_gap", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kfmmc_host_bridge.md
Name: kfmmc_host_bridge

Overview:
CPU-side port interface placed directly upstream of the MMC drive block. It decodes an 8-bit CPU I/O window into the drive's write strobes: block address bytes, command, and transmit data. It drains received bytes from the drive into a small FIFO using the drive's read_byte_interrupt / read_data handshake. It also latches the drive's transient completion interrupts into sticky, maskable status for a single CPU interrupt line.

Parameters:
fifo_depth, 4, receive FIFO entries (power of two, 2..16)
Derived, not a parameter: count width = $clog2(fifo_depth+1).

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
cpu_chip_select  input  1  CPU access to this window
cpu_address  input  3  register select
cpu_write  input  1  write strobe (level, may span several cycles)
cpu_read  input  1  read strobe (level, may span several cycles)
cpu_data_in  input  8  CPU write data
cpu_data_out  output  8  CPU read data
interrupt  output  1  CPU interrupt request
data_bus  output  8  data to drive
write_block_address_1..4  output  1 each  drive block address byte strobes
write_command  output  1  drive command strobe
write_data  output  1  drive transmit-data strobe
read_data  output  1  receive-byte acknowledge to drive
read_data_byte  input  8  drive received byte
drive_busy, read_interface_error, write_interface_error  input  1 each  drive state
read_byte_interrupt, read_completion_interrupt, request_write_data_interrupt, write_completion_interrupt  input  1 each  drive interrupts

Behaviour:
- Reset (reset_n low, async): all strobes 0; data_bus 0x00; FIFO empty; sticky flags 0; interrupt_enable 0x00; ack FSM IDLE; interrupt 0.
- Write access starts on the rising edge of (cpu_chip_select & cpu_write). Address and data are sampled on that edge. Exactly one 1-cycle strobe is registered on the next clock, with data_bus holding the sampled data from that cycle until the next write.
- Register map, write side:
  - 0 = write_data
  - 1 = write_command
  - 2..5 = write_block_address_1..4
  - 6 = interrupt_enable[3:0]
  - 7 = write FIFO flush (any value)
- Register map, read side. cpu_data_out is combinational while cs & read, otherwise 0x00.
  - 0 = FIFO head; 0x00 if empty.
  - 1 = status {drive_busy, read_interface_error, write_interface_error, 1'b0, fifo_full, ~fifo_empty, 2'b00}.
  - 2..5 = 0x00.
  - 6 = {interrupt_enable[3:0], sticky[3:0]}.
  - 7 = {4'h0, fifo count, zero-extended}.
- Read side effects occur on the falling edge of (cs & cpu_read), one clock after it is detected:
  - Address 0: pop if not empty; no effect if empty.
  - Address 6: clear sticky[3:1].
- Sticky bits:
  - [0] = ~fifo_empty (live, not sticky).
  - [1] = read_completion.
  - [2] = request_write_data (live copy of the drive input).
  - [3] = write_completion.
  - [1] and [3] are set on the input level being high and held until a status-6 read.
  - Set and clear in the same cycle: set wins.
- interrupt = |(interrupt_enable[3:0] & sticky[3:0]), registered (1-cycle latency).
- Ack FSM:
  - IDLE: if read_byte_interrupt & ~fifo_full, push read_data_byte and go to ACK. If the FIFO is full, stay in IDLE; the drive stalls.
  - ACK: read_data=1 for exactly one cycle, then go to HOLD.
  - HOLD: one cycle, ignores read_byte_interrupt (drive clears its flag on seeing read_data), then go to IDLE.
  - Minimum 3 cycles per byte.
- FIFO:
  - Push and pop in the same cycle: count unchanged; allowed when full because pop frees the entry.
  - Pointers wrap modulo fifo_depth.
  - Flush while ACK/HOLD: the FIFO is emptied and the FSM completes normally; the byte pushed in that cycle is discarded.
- Simultaneous CPU write to address 0 and an ACK cycle are independent: write_data and read_data may both be high.
- Reset mid-operation: all state is cleared immediately; a pending drive read_byte_interrupt is re-served after reset release.

Decomposition:
- Package kfmmc_host_pkg:
  - register address localparams (REG_DATA=0 .. REG_COUNT=7)
  - sticky bit index constants
  - typedef enum logic [1:0] {ACK_IDLE, ACK_STROBE, ACK_HOLD} ack_state_t
- Sub-module kfmmc_byte_fifo: parameterised depth, push/pop/flush, head, empty, full, count.

Test Plan:
- CPU writes 0x12,0x34,0x56,0x78 to addresses 2..5, then 0x51 to address 1 -> write_block_address_1..4 and write_command each pulse once for 1 cycle, with data_bus = 0x12,0x34,0x56,0x78,0x51 respectively; a 5-cycle-long cpu_write still yields one pulse.
- Drive presents bytes 0xA0..0xA5 via read_byte_interrupt with no CPU reads and fifo_depth=4 -> 4 read_data pulses, then stall; status = 0x0C; count = 4. Reading address 0 returns 0xA0, and a 5th ack follows within 3 cycles.
- Back-to-back bytes -> read_data pulses are spaced exactly 3 cycles apart; no byte is captured twice.
- Enable=0x2; pulse read_completion_interrupt for 1 cycle -> interrupt rises 1 cycle later and stays high. Reading address 6 returns 0x22 and clears it; interrupt falls the cycle after.
- Read of address 0 with the FIFO empty -> returns 0x00; count stays 0; no underflow.
- Assert reset_n low during ACK -> read_data=0 and FIFO empty asynchronously; after release, the pending byte is captured once.
